// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-byte holding register in front of an 8N1 shifter.
// Bit timing comes from an external baud_tick, BIT_TICKS ticks per serial bit.
module uart_tx_ctrl #(
  parameter int BIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       baud_tick,
  input  logic       clr_ovr,
  output logic       tx,
  output logic       tx_rdy,
  output logic       busy,
  output logic       overrun
);

  // state  | meaning
  // IDLE   | line idle high, waiting for holding register to fill
  // START  | driving start bit (0)
  // DATA   | shifting out 8 data bits, LSB first
  // STOP   | driving stop bit (1)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  logic [1:0]    state;
  logic [7:0]    hold;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tick_cnt;
  logic          bit_end;

  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      hold     <= 8'h00;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      tick_cnt <= '0;
      tx       <= 1'b1;
      tx_rdy   <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      // a dropped write beats a simultaneous clear
      if (wr && !tx_rdy)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!tx_rdy) begin
            shift    <= hold;
            tx_rdy   <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            // back-to-back frame: reload straight into START, no idle gap
            if (!tx_rdy) begin
              shift   <= hold;
              tx_rdy  <= 1'b1;
              bit_cnt <= 3'd0;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase

      // acceptance and transfer are mutually exclusive (tx_rdy=1 vs tx_rdy=0)
      if (wr && tx_rdy) begin
        hold   <= din;
        tx_rdy <= 1'b0;
      end
    end
  end

endmodule
